// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states,
// opcode/funct fields, ALU operations and datapath select values.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_ALU_WB   = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDI_EX  = 4'd9,
    S_ADDI_WB  = 4'd10,
    S_JUMP     = 4'd11,
    S_RST      = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// ALU operation select: fixed add/sub for address and branch states,
// funct-driven operation in EXEC, plus a flag for recognised funct codes.
module alu_decoder (
  input  logic [3:0] state,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       funct_valid
);
  import mips_pkg::*;

  logic [2:0] fn_ctrl;

  // Translate funct to an ALU op, then pick the op the current state needs
  always_comb begin
    funct_valid = 1'b1;
    fn_ctrl     = ALU_AND;
    case (funct)
      FN_ADD:  fn_ctrl = ALU_ADD;
      FN_SUB:  fn_ctrl = ALU_SUB;
      FN_AND:  fn_ctrl = ALU_AND;
      FN_OR:   fn_ctrl = ALU_OR;
      FN_SLT:  fn_ctrl = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase

    alu_ctrl = '0;
    case (state)
      S_FETCH, S_DECODE, S_MEM_ADDR, S_ADDI_EX: alu_ctrl = ALU_ADD;
      S_BRANCH:                                 alu_ctrl = ALU_SUB;
      S_EXEC:                                   alu_ctrl = fn_ctrl;
      default:                                  alu_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main control: state sequencing, datapath selects and
// enables, sticky illegal-instruction flag, retired/cycle counters.
module mc_control_fsm #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_ctrl,
  output logic [1:0]       pc_src,
  output logic             instr_done,
  output logic             illegal,
  output logic [3:0]       state_out,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);
  import mips_pkg::*;

  state_t state_q, state_d;
  logic   funct_valid;
  logic   opcode_valid;

  alu_decoder u_alu_decoder (
    .state       (state_q),
    .funct       (funct),
    .alu_ctrl    (alu_ctrl),
    .funct_valid (funct_valid)
  );

  assign state_out = state_q;

  // Opcodes this control unit knows how to sequence
  always_comb begin
    case (opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: opcode_valid = 1'b1;
      default:                                       opcode_valid = 1'b0;
    endcase
  end

  // State register; asynchronous reset aborts any instruction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_RST;
    else        state_q <= state_d;
  end

  // Next-state sequencing
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_RST:      state_d = S_FETCH;
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   state_d = mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC:     state_d = funct_valid ? S_ALU_WB : S_FETCH;
      S_ALU_WB:   state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_ADDI_WB:  state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore datapath controls; pc_en, ir_write and instr_done take a handshake
  // input only in FETCH, BRANCH and MEM_WR
  always_comb begin
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    pc_src     = PCSRC_ALU;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE:   alu_src_b = SRCB_IMM_SH2;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC:     alu_src_a = 1'b1;
      S_ALU_WB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        pc_src     = PCSRC_ALUOUT;
        pc_en      = zero;
        instr_done = 1'b1;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_src     = PCSRC_JUMP;
        pc_en      = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Sticky illegal flag: unknown opcode in DECODE or unknown funct in EXEC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      illegal <= 1'b0;
    else if ((state_q == S_DECODE && !opcode_valid) ||
             (state_q == S_EXEC && !funct_valid))
      illegal <= 1'b1;
  end

  // Free-running cycle and retired-instruction counters, wrapping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (state_q != S_RST) cycle_count <= cycle_count + CNT_W'(1);
      if (instr_done)       instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm with 4-bit counters so wrap is reachable.
module tb_mc_control_fsm;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [5:0]    opcode = '0;
  logic [5:0]    funct = '0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b1;
  logic          pc_en, iord, mem_read, mem_write, ir_write, reg_dst;
  logic          mem_to_reg, reg_write, alu_src_a, instr_done, illegal;
  logic [1:0]    alu_src_b, pc_src;
  logic [2:0]    alu_ctrl;
  logic [3:0]    state_out;
  logic [CW-1:0] instr_count, cycle_count;
  logic [16:0]   outs;

  int unsigned passed = 0;
  int unsigned total  = 0;

  // {pc_en iord mem_read mem_write ir_write}_{reg_dst mem_to_reg reg_write alu_src_a}_srcb_ctrl_pcsrc_done
  localparam logic [16:0] O_FETCH   = 17'b10101_0000_01_010_00_0;
  localparam logic [16:0] O_DECODE  = 17'b00000_0000_11_010_00_0;
  localparam logic [16:0] O_MADDR   = 17'b00000_0001_10_010_00_0;
  localparam logic [16:0] O_MRD     = 17'b01100_0000_00_000_00_0;
  localparam logic [16:0] O_MWB     = 17'b00000_0110_00_000_00_1;
  localparam logic [16:0] O_MWR_W   = 17'b01010_0000_00_000_00_0;
  localparam logic [16:0] O_MWR_R   = 17'b01010_0000_00_000_00_1;
  localparam logic [16:0] O_EX_SUB  = 17'b00000_0001_00_110_00_0;
  localparam logic [16:0] O_EX_BAD  = 17'b00000_0001_00_000_00_0;
  localparam logic [16:0] O_ALUWB   = 17'b00000_1010_00_000_00_1;
  localparam logic [16:0] O_BR_Z1   = 17'b10000_0001_00_110_01_1;
  localparam logic [16:0] O_BR_Z0   = 17'b00000_0001_00_110_01_1;
  localparam logic [16:0] O_ADDI_EX = 17'b00000_0001_10_010_00_0;
  localparam logic [16:0] O_ADDI_WB = 17'b00000_0010_00_000_00_1;
  localparam logic [16:0] O_JUMP    = 17'b10000_0000_00_000_10_1;

  assign outs = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                 reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, instr_done};

  always #5 clk = ~clk;

  mc_control_fsm #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .pc_src(pc_src),
    .instr_done(instr_done), .illegal(illegal), .state_out(state_out),
    .instr_count(instr_count), .cycle_count(cycle_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    total++; if (state_out !== 4'd15) $display("FAIL reset_state: got %0d want 15", state_out); else passed++;
    total++; if (outs !== 17'd0) $display("FAIL reset_outs: got %b want 0", outs); else passed++;
    total++; if (instr_count !== 4'd0 || cycle_count !== 4'd0)
      $display("FAIL reset_counts: got %0d/%0d want 0/0", instr_count, cycle_count); else passed++;
    total++; if (illegal !== 1'b0) $display("FAIL reset_illegal: got %b want 0", illegal); else passed++;
    reset = 1'b1;
    tick();
    total++; if (state_out !== 4'd0) $display("FAIL release_state: got %0d want 0", state_out); else passed++;
    total++; if (cycle_count !== 4'd0) $display("FAIL release_cycles: got %0d want 0", cycle_count); else passed++;
  endtask

  task automatic test_lw();
    logic [3:0]  st [5];
    logic [16:0] ov [5];
    st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    ov = '{O_FETCH, O_DECODE, O_MADDR, O_MRD, O_MWB};
    opcode = 6'h23; mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      total++; if (state_out !== st[i]) $display("FAIL lw_state[%0d]: got %0d want %0d", i, state_out, st[i]); else passed++;
      total++; if (outs !== ov[i]) $display("FAIL lw_outs[%0d]: got %b want %b", i, outs, ov[i]); else passed++;
      tick();
    end
    total++; if (state_out !== 4'd0) $display("FAIL lw_end_state: got %0d want 0", state_out); else passed++;
    total++; if (instr_count !== 4'd1) $display("FAIL lw_instr: got %0d want 1", instr_count); else passed++;
    total++; if (cycle_count !== 4'd5) $display("FAIL lw_cycles: got %0d want 5", cycle_count); else passed++;
  endtask

  task automatic test_rtype();
    logic [3:0]  st [4];
    logic [16:0] ov [4];
    st = '{4'd0, 4'd1, 4'd6, 4'd7};
    ov = '{O_FETCH, O_DECODE, O_EX_SUB, O_ALUWB};
    opcode = 6'h00; funct = 6'h22;
    #1;
    for (int i = 0; i < 4; i++) begin
      total++; if (state_out !== st[i]) $display("FAIL rtype_state[%0d]: got %0d want %0d", i, state_out, st[i]); else passed++;
      total++; if (outs !== ov[i]) $display("FAIL rtype_outs[%0d]: got %b want %b", i, outs, ov[i]); else passed++;
      tick();
    end
    total++; if (instr_count !== 4'd2 || cycle_count !== 4'd9)
      $display("FAIL rtype_counts: got %0d/%0d want 2/9", instr_count, cycle_count); else passed++;
  endtask

  task automatic test_beq();
    logic [3:0]  st [3];
    logic [16:0] ov [3];
    logic [3:0]  ic [2];
    logic [3:0]  cc [2];
    st = '{4'd0, 4'd1, 4'd8};
    ic = '{4'd3, 4'd4};
    cc = '{4'd12, 4'd15};
    opcode = 6'h04;
    for (int r = 0; r < 2; r++) begin
      zero = (r == 0);
      ov = '{O_FETCH, O_DECODE, (r == 0) ? O_BR_Z1 : O_BR_Z0};
      #1;
      for (int i = 0; i < 3; i++) begin
        total++; if (state_out !== st[i]) $display("FAIL beq%0d_state[%0d]: got %0d want %0d", r, i, state_out, st[i]); else passed++;
        total++; if (outs !== ov[i]) $display("FAIL beq%0d_outs[%0d]: got %b want %b", r, i, outs, ov[i]); else passed++;
        tick();
      end
      total++; if (instr_count !== ic[r] || cycle_count !== cc[r])
        $display("FAIL beq%0d_counts: got %0d/%0d want %0d/%0d", r, instr_count, cycle_count, ic[r], cc[r]); else passed++;
    end
    zero = 1'b0;
  endtask

  task automatic test_sw_wait();
    logic [3:0]  st [7];
    logic [16:0] ov [7];
    logic        rdy [7];
    st  = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
    ov  = '{O_FETCH, O_DECODE, O_MADDR, O_MWR_W, O_MWR_W, O_MWR_W, O_MWR_R};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    opcode = 6'h2B;
    for (int i = 0; i < 7; i++) begin
      mem_ready = rdy[i];
      #1;
      total++; if (state_out !== st[i]) $display("FAIL sw_state[%0d]: got %0d want %0d", i, state_out, st[i]); else passed++;
      total++; if (outs !== ov[i]) $display("FAIL sw_outs[%0d]: got %b want %b", i, outs, ov[i]); else passed++;
      tick();
    end
    mem_ready = 1'b1;
    #1;
    total++; if (state_out !== 4'd0) $display("FAIL sw_end_state: got %0d want 0", state_out); else passed++;
    total++; if (instr_count !== 4'd5 || cycle_count !== 4'd6)
      $display("FAIL sw_counts: got %0d/%0d want 5/6", instr_count, cycle_count); else passed++;
  endtask

  task automatic test_addi();
    logic [3:0]  st [4];
    logic [16:0] ov [4];
    st = '{4'd0, 4'd1, 4'd9, 4'd10};
    ov = '{O_FETCH, O_DECODE, O_ADDI_EX, O_ADDI_WB};
    opcode = 6'h08;
    #1;
    for (int i = 0; i < 4; i++) begin
      total++; if (state_out !== st[i]) $display("FAIL addi_state[%0d]: got %0d want %0d", i, state_out, st[i]); else passed++;
      total++; if (outs !== ov[i]) $display("FAIL addi_outs[%0d]: got %b want %b", i, outs, ov[i]); else passed++;
      tick();
    end
    total++; if (instr_count !== 4'd6 || cycle_count !== 4'd10)
      $display("FAIL addi_counts: got %0d/%0d want 6/10", instr_count, cycle_count); else passed++;
  endtask

  task automatic test_illegal_opcode();
    opcode = 6'h3F;
    #1;
    tick();
    total++; if (state_out !== 4'd1) $display("FAIL illop_decode: got %0d want 1", state_out); else passed++;
    total++; if (illegal !== 1'b0) $display("FAIL illop_early: got %b want 0", illegal); else passed++;
    tick();
    total++; if (state_out !== 4'd0) $display("FAIL illop_next: got %0d want 0", state_out); else passed++;
    total++; if (illegal !== 1'b1) $display("FAIL illop_flag: got %b want 1", illegal); else passed++;
    total++; if (instr_count !== 4'd6 || cycle_count !== 4'd12)
      $display("FAIL illop_counts: got %0d/%0d want 6/12", instr_count, cycle_count); else passed++;
  endtask

  task automatic test_reset_mid_exec();
    opcode = 6'h00; funct = 6'h20;
    #1;
    tick();
    tick();
    total++; if (state_out !== 4'd6) $display("FAIL mid_exec_state: got %0d want 6", state_out); else passed++;
    total++; if (illegal !== 1'b1) $display("FAIL mid_sticky: got %b want 1", illegal); else passed++;
    #2;
    reset = 1'b0;
    #1;
    total++; if (state_out !== 4'd15) $display("FAIL mid_rst_state: got %0d want 15", state_out); else passed++;
    total++; if (outs !== 17'd0) $display("FAIL mid_rst_outs: got %b want 0", outs); else passed++;
    total++; if (instr_count !== 4'd0 || cycle_count !== 4'd0 || illegal !== 1'b0)
      $display("FAIL mid_rst_regs: got %0d/%0d/%b want 0/0/0", instr_count, cycle_count, illegal); else passed++;
    tick();
    total++; if (mem_write !== 1'b0 || reg_write !== 1'b0)
      $display("FAIL mid_rst_strobes: got %b%b want 00", mem_write, reg_write); else passed++;
    reset = 1'b1;
    tick();
    total++; if (state_out !== 4'd0 || cycle_count !== 4'd0)
      $display("FAIL mid_release: got %0d/%0d want 0/0", state_out, cycle_count); else passed++;
  endtask

  task automatic test_illegal_funct();
    logic [3:0]  st [3];
    logic [16:0] ov [3];
    st = '{4'd0, 4'd1, 4'd6};
    ov = '{O_FETCH, O_DECODE, O_EX_BAD};
    opcode = 6'h00; funct = 6'h3F;
    #1;
    for (int i = 0; i < 3; i++) begin
      total++; if (state_out !== st[i]) $display("FAIL illfn_state[%0d]: got %0d want %0d", i, state_out, st[i]); else passed++;
      total++; if (outs !== ov[i]) $display("FAIL illfn_outs[%0d]: got %b want %b", i, outs, ov[i]); else passed++;
      tick();
    end
    total++; if (state_out !== 4'd0 || illegal !== 1'b1)
      $display("FAIL illfn_after: got %0d/%b want 0/1", state_out, illegal); else passed++;
    total++; if (instr_count !== 4'd0 || cycle_count !== 4'd3)
      $display("FAIL illfn_counts: got %0d/%0d want 0/3", instr_count, cycle_count); else passed++;
  endtask

  task automatic test_wrap();
    opcode = 6'h02;
    #1;
    for (int i = 0; i < 16; i++) begin
      tick();
      tick();
      total++; if (outs !== O_JUMP || state_out !== 4'd11)
        $display("FAIL wrap_jump[%0d]: got %0d/%b want 11/%b", i, state_out, outs, O_JUMP); else passed++;
      tick();
      if (i == 14) begin
        total++; if (instr_count !== 4'd15) $display("FAIL wrap_pre: got %0d want 15", instr_count); else passed++;
      end
    end
    total++; if (instr_count !== 4'd0) $display("FAIL wrap_instr: got %0d want 0", instr_count); else passed++;
    total++; if (cycle_count !== 4'd3) $display("FAIL wrap_cycles: got %0d want 3", cycle_count); else passed++;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype();
    test_beq();
    test_sw_wait();
    test_addi();
    test_illegal_opcode();
    test_reset_mid_exec();
    test_illegal_funct();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
